// File: rtl/pid_controller.sv
// Fixed-point PID regulator: one correction every five cycles, with saturation at every stage.
// state | meaning: IDLE wait for run | SAMPLE latch e | PROP P | INTEG integral,I | DERIV D,e_prev | SUM out,strobe
module pid_controller #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS  = 13
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               write_enable,
  input  logic               iterate_enable,
  input  logic [D_WIDTH-1:0] reg_addr,
  input  logic [D_WIDTH-1:0] reg_data,
  input  logic [D_WIDTH-1:0] target,
  input  logic [D_WIDTH-1:0] measurement,
  output logic [D_WIDTH-1:0] out,
  output logic               out_valid
);

  // Working width covers the D_WIDTH+1 derivative difference times a gain.
  localparam int W = 2*D_WIDTH + 2;
  localparam logic signed [W-1:0] SMAX = {{(W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {{(W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_PROP,
    S_INTEG,
    S_DERIV,
    S_SUM
  } state_t;

  state_t             state_q;
  logic [D_WIDTH-1:0] kp_q, ki_q, kd_q;
  logic [D_WIDTH-1:0] e_q, eprev_q, integ_q;
  logic [D_WIDTH-1:0] p_q, i_q, d_q;
  logic [D_WIDTH-1:0] e_d, p_d, integ_d, i_d, d_d, out_d;
  logic signed [W-1:0] prod_p, prod_i, prod_d;
  logic               run_ok;

  function automatic logic signed [W-1:0] sx(input logic [D_WIDTH-1:0] v);
    return {{(W-D_WIDTH){v[D_WIDTH-1]}}, v};
  endfunction

  function automatic logic [D_WIDTH-1:0] sat(input logic signed [W-1:0] v);
    logic [D_WIDTH-1:0] r;
    if (v > SMAX)      r = SMAX[D_WIDTH-1:0];
    else if (v < SMIN) r = SMIN[D_WIDTH-1:0];
    else               r = v[D_WIDTH-1:0];
    return r;
  endfunction

  assign run_ok  = iterate_enable & write_enable;
  assign e_d     = sat(sx(target) - sx(measurement));
  assign prod_p  = sx(kp_q) * sx(e_q);
  assign p_d     = sat(prod_p >>> Q_BITS);
  assign integ_d = sat(sx(integ_q) + sx(e_q));
  assign prod_i  = sx(ki_q) * sx(integ_d);
  assign i_d     = sat(prod_i >>> Q_BITS);
  assign prod_d  = sx(kd_q) * (sx(e_q) - sx(eprev_q));
  assign d_d     = sat(prod_d >>> Q_BITS);
  assign out_d   = sat(sx(p_q) + sx(i_q) + sx(d_q));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e_q       <= '0;
      eprev_q   <= '0;
      integ_q   <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      // Gain writes land in any state; later stages of this iteration see them.
      if (!write_enable) begin
        if (reg_addr == D_WIDTH'(0)) kp_q <= reg_data;
        if (reg_addr == D_WIDTH'(1)) ki_q <= reg_data;
        if (reg_addr == D_WIDTH'(2)) kd_q <= reg_data;
      end
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_ok) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          e_q     <= e_d;
          state_q <= S_PROP;
        end
        S_PROP: begin
          p_q     <= p_d;
          state_q <= S_INTEG;
        end
        S_INTEG: begin
          integ_q <= integ_d;
          i_q     <= i_d;
          state_q <= S_DERIV;
        end
        S_DERIV: begin
          d_q     <= d_d;
          eprev_q <= e_q;
          state_q <= S_SUM;
        end
        S_SUM: begin
          out       <= out_d;
          out_valid <= 1'b1;
          state_q   <= run_ok ? S_SAMPLE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller.sv
// Directed and randomized checks of pid_controller against an integer PID model.
module tb_pid_controller;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        write_enable = 1'b1;
  logic        iterate_enable = 1'b0;
  logic [15:0] reg_addr = '0;
  logic [15:0] reg_data = '0;
  logic [15:0] target = '0;
  logic [15:0] measurement = '0;
  logic [15:0] out;
  logic        out_valid;

  int     ncmp = 0;
  int     nerr = 0;
  int     dbl = 0;
  logic   prev_ov = 1'b0;
  longint kp_m = 0, ki_m = 0, kd_m = 0, integ_m = 0, eprev_m = 0;

  pid_controller #(.D_WIDTH(16), .Q_BITS(13)) dut (
    .clk(clk),
    .rstb(rstb),
    .write_enable(write_enable),
    .iterate_enable(iterate_enable),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .target(target),
    .measurement(measurement),
    .out(out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && prev_ov) dbl++;
    prev_ov = out_valid;
  end

  function automatic longint msat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint s16(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // One full P+I+D iteration on plain integers; floor shift models truncation toward -inf.
  function automatic longint model_iter(longint t, longint m);
    longint e, p, i, d;
    e       = msat(t - m);
    p       = msat((kp_m * e) >>> 13);
    integ_m = msat(integ_m + e);
    i       = msat((ki_m * integ_m) >>> 13);
    d       = msat((kd_m * (e - eprev_m)) >>> 13);
    eprev_m = e;
    return msat(p + i + d);
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic write_gain(input int addr, input int val);
    write_enable = 1'b0;
    reg_addr     = addr[15:0];
    reg_data     = val[15:0];
    @(posedge clk); #1;
    write_enable = 1'b1;
    if (addr == 0) kp_m = s16(val[15:0]);
    if (addr == 1) ki_m = s16(val[15:0]);
    if (addr == 2) kd_m = s16(val[15:0]);
  endtask

  task automatic do_reset();
    iterate_enable = 1'b0;
    rstb = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    kp_m = 0; ki_m = 0; kd_m = 0; integ_m = 0; eprev_m = 0;
  endtask

  // Applies inputs, waits (bounded) for the strobe and checks out; with last set the run stops after it.
  task automatic do_iter(input string tag, input int t, input int m, input bit last, input int exp_lat);
    longint expv;
    int     cyc;
    bit     seen;
    target         = t[15:0];
    measurement    = m[15:0];
    iterate_enable = 1'b1;
    expv = model_iter(longint'(t), longint'(m));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
      if (last && cyc == 2) iterate_enable = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check_int({tag, "_strobe"}, int'(seen), 1);
    check16(tag, out, expv[15:0]);
    if (exp_lat > 0) check_int({tag, "_lat"}, cyc, exp_lat);
  endtask

  initial begin
    longint expv;
    int     nstrobe;
    int     rt, rm;

    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    check16("reset_out", out, 16'd0);
    check_int("reset_valid", int'(out_valid), 0);

    write_gain(0, 'h0200);
    write_gain(1, 'h1000);
    write_gain(2, 0);
    do_iter("pi1", 1600, 0, 1'b0, 6);
    check16("pi1_const", out, 16'd900);
    do_iter("pi2", 1600, 0, 1'b1, 5);
    check16("pi2_const", out, 16'd1700);

    do_reset();
    write_gain(0, 0);
    write_gain(1, 0);
    write_gain(2, 'h2000);
    do_iter("d1", 100, 0, 1'b0, 6);
    check16("d1_const", out, 16'd100);
    do_iter("d2", 100, 0, 1'b0, 5);
    check16("d2_const", out, 16'd0);
    do_iter("d3", 100, 0, 1'b0, 5);
    check16("d3_const", out, 16'd0);
    do_iter("d4", 100, 50, 1'b1, 5);
    check16("d4_const", out, 16'hFFCE);

    write_gain(0, 'h2000);
    write_gain(1, 0);
    write_gain(2, 0);
    do_iter("sat_hi", 32767, -32768, 1'b1, 6);
    check16("sat_hi_const", out, 16'h7FFF);
    do_iter("sat_lo", -32768, 32767, 1'b1, 6);
    check16("sat_lo_const", out, 16'h8000);

    write_gain(0, 'h0200);
    do_iter("trunc", 0, 1, 1'b1, 6);
    check16("trunc_const", out, 16'hFFFF);

    write_gain(0, int'($urandom_range(0, 32768)) - 16384);
    write_gain(1, int'($urandom_range(0, 4096)) - 2048);
    write_gain(2, int'($urandom_range(0, 32768)) - 16384);
    for (int i = 0; i < 30; i++) begin
      rt = int'($urandom_range(0, 65535)) - 32768;
      rm = int'($urandom_range(0, 65535)) - 32768;
      do_iter($sformatf("rand%0d", i), rt, rm, (i == 29), (i == 0) ? 6 : 5);
    end

    // Hold write_enable low across an in-flight iteration; only that strobe may appear.
    do_iter("ws_pre", 1000, 200, 1'b0, 6);
    expv = model_iter(1000, 200);
    write_enable = 1'b0;
    reg_addr     = 16'd3;
    reg_data     = 16'h7FFF;
    nstrobe      = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nstrobe++;
        check16("ws_inflight", out, expv[15:0]);
      end
      if (k == 9) begin
        reg_addr = 16'd0;
        reg_data = 16'h0400;
      end
    end
    write_enable = 1'b1;
    kp_m = 'h0400;
    check_int("ws_strobes", nstrobe, 1);
    do_iter("ws_post", 1000, 200, 1'b1, 6);

    // Asynchronous reset three edges into an iteration.
    target         = 16'd5000;
    measurement    = 16'd0;
    iterate_enable = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check16("rst_out", out, 16'd0);
    check_int("rst_valid", int'(out_valid), 0);
    #1;
    rstb = 1'b1;
    kp_m = 0; ki_m = 0; kd_m = 0; integ_m = 0; eprev_m = 0;
    do_iter("rst_run", 5000, 0, 1'b1, 6);
    check16("rst_run_const", out, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    check_int("no_double_strobe", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
